// File: rtl/mem_arbiter.sv
// Round-robin icache/dcache arbiter onto a single-ported RAM; grant 1 cycle after request, ack in first ACCESS cycle.
// Backpressure: the unserved cache sees wait=1 and holds its request; a RAM ERROR or timeout aborts with a bus_err pulse.
module mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, ISERVE, DSERVE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  grant_t           last_grant, last_grant_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dreq, req_held, is_i;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    bus_err      = 1'b0;
    is_i         = (state == ISERVE);
    req_held     = is_i ? iREN : dreq;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (iREN && dreq)
          state_n = (last_grant == GRANT_I) ? DSERVE : ISERVE;
        else if (iREN)
          state_n = ISERVE;
        else if (dreq)
          state_n = DSERVE;
      end
      ISERVE, DSERVE: begin
        if (is_i) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end else begin
          // a write takes precedence over a simultaneous read request
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          ramstore = dWEN ? dstore : '0;
          ramaddr  = daddr;
        end

        if (!req_held) begin
          state_n = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          if (is_i) begin
            iwait        = 1'b0;
            iload        = ramload;
            last_grant_n = GRANT_I;
          end else begin
            dwait        = 1'b0;
            dload        = dWEN ? '0 : ramload;
            last_grant_n = GRANT_D;
          end
          state_n = IDLE;
        end else if (ramstate == RAM_ERROR || cnt == CNT_LAST) begin
          // abort; the cache keeps its request up and is re-granted from IDLE
          bus_err = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
